// File: rtl/cpu_multicycle_control_pkg.sv
// Shared control definitions for the multi-cycle LEGv8 datapath.
// Holds FSM states, opcode constants, ALU encodings and the per-state control word.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_WB_R   = 4'd3,
      S_ADDR   = 4'd4,
      S_MRD    = 4'd5,
      S_WB_M   = 4'd6,
      S_MWR    = 4'd7,
      S_CBZ    = 4'd8,
      S_BR     = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   typedef struct packed {
      logic is_r;
      logic is_ldur;
      logic is_stur;
      logic is_cbz;
      logic is_b;
      logic illegal;
   } op_class_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg2loc;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   // Static (state-only) part of the control word.
   function automatic ctrl_t state_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      unique case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM4;
            c.alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: c.reg_write = 1'b1;
         S_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MRD: begin
            c.ior_d    = 1'b1;
            c.mem_read = 1'b1;
         end
         S_WB_M: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MWR: begin
            c.ior_d     = 1'b1;
            c.mem_write = 1'b1;
            c.reg2loc   = 1'b1;
         end
         S_CBZ: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_REG;
            c.alu_op        = ALUOP_PASSB;
            c.reg2loc       = 1'b1;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 1'b1;
         end
         S_BR: begin
            c.pc_write  = 1'b1;
            c.pc_source = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// Control <-> datapath bundle for the multi-cycle LEGv8 core.
// master: control FSM (drives strobes/muxes); slave: datapath (drives Opcode/Zero/MemReady).
interface cpu_multicycle_control_if #(
   parameter int CNT_W = 32,
   parameter int OPC_W = 11
);
   logic [OPC_W-1:0] Opcode;
   logic             Zero;
   logic             MemReady;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             PCSource;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IRWrite;
   logic             Reg2Loc;
   logic             MemtoReg;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [CNT_W-1:0] InstrCount;
   logic             Halted;

   modport master (
      input  Opcode, Zero, MemReady,
      output PCWrite, PCWriteCond, PCSource, IorD,
      output MemRead, MemWrite, IRWrite, Reg2Loc,
      output MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
      output ALUOp, InstrCount, Halted
   );

   modport slave (
      output Opcode, Zero, MemReady,
      input  PCWrite, PCWriteCond, PCSource, IorD,
      input  MemRead, MemWrite, IRWrite, Reg2Loc,
      input  MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
      input  ALUOp, InstrCount, Halted
   );
endinterface

// File: rtl/cpu_multicycle_control_opdecode.sv
// Combinational opcode classifier for the LEGv8 control FSM.
// Ports: opcode (IR[31:21]) in, cls {is_r,is_ldur,is_stur,is_cbz,is_b,illegal} out.
module cpu_ctrl_opdecode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 11
) (
   input  logic [OPC_W-1:0] opcode,
   output op_class_t        cls
);

   always_comb begin
      cls = '0;
      cls.is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
      cls.is_ldur = (opcode == OP_LDUR);
      cls.is_stur = (opcode == OP_STUR);
      cls.is_cbz  = (opcode[OPC_W-1 -: 8] == OP_CBZ_PFX);
      cls.is_b    = (opcode[OPC_W-1 -: 6] == OP_B_PFX);
      cls.illegal = ~(cls.is_r | cls.is_ldur | cls.is_stur |
                      cls.is_cbz | cls.is_b);
   end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multi-cycle control FSM for the 64-bit LEGv8 datapath: sequences fetch..writeback,
// stalls on MemReady, counts retired instructions, halts on illegal opcodes.
// Ports: Clock, Reset (async high), bus (master modport: all strobes, InstrCount, Halted).
module cpu_multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int OPC_W = 11
) (
   input logic                       Clock,
   input logic                       Reset,
   cpu_multicycle_control_if.master  bus
);

   state_t           state;
   state_t           nxt;
   ctrl_t            ctl;
   op_class_t        cls;
   logic [CNT_W-1:0] cnt;
   logic             halted;
   logic             retire;
   logic             fetch_go;

   cpu_ctrl_opdecode #(.OPC_W(OPC_W)) u_dec (
      .opcode (bus.Opcode),
      .cls    (cls)
   );

   always_comb begin
      nxt    = state;
      retire = 1'b0;
      unique case (state)
         S_FETCH: if (bus.MemReady) nxt = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               cls.is_r:                nxt = S_EXEC_R;
               cls.is_ldur, cls.is_stur: nxt = S_ADDR;
               cls.is_cbz:              nxt = S_CBZ;
               cls.is_b:                nxt = S_BR;
               cls.illegal:             nxt = S_HALT;
               default:                 nxt = S_HALT;
            endcase
         end
         S_EXEC_R: nxt = S_WB_R;
         S_WB_R: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_ADDR: nxt = cls.is_stur ? S_MWR : S_MRD;
         S_MRD: if (bus.MemReady) nxt = S_WB_M;
         S_WB_M: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_MWR: begin
            if (bus.MemReady) begin
               nxt    = S_FETCH;
               retire = 1'b1;
            end
         end
         S_CBZ, S_BR: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         default: nxt = S_HALT;
      endcase
   end

   // Control word is registered from the next state so outputs come
   // straight off flops and the async reset clears strobes immediately.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state  <= S_FETCH;
         ctl    <= state_ctrl(S_FETCH);
         cnt    <= '0;
         halted <= 1'b0;
      end else begin
         state <= nxt;
         ctl   <= state_ctrl(nxt);
         if (retire) cnt <= cnt + CNT_W'(1);
         if (nxt == S_HALT) halted <= 1'b1;
      end
   end

   // Fetch commit waits on memory; held off while in reset.
   assign fetch_go = (state == S_FETCH) & bus.MemReady & ~Reset;

   assign bus.PCWrite     = ctl.pc_write | fetch_go;
   assign bus.IRWrite     = fetch_go;
   assign bus.PCWriteCond = ctl.pc_write_cond;
   assign bus.PCSource    = ctl.pc_source;
   assign bus.IorD        = ctl.ior_d;
   assign bus.MemRead     = ctl.mem_read;
   assign bus.MemWrite    = ctl.mem_write;
   // IR is only valid once in DECODE, so the STUR/CBZ read-port select
   // there comes from the live opcode rather than the registered word.
   assign bus.Reg2Loc     = ctl.reg2loc |
                            ((state == S_DECODE) & (cls.is_stur | cls.is_cbz));
   assign bus.MemtoReg    = ctl.mem_to_reg;
   assign bus.RegWrite    = ctl.reg_write;
   assign bus.ALUSrcA     = ctl.alu_src_a;
   assign bus.ALUSrcB     = ctl.alu_src_b;
   assign bus.ALUOp       = ctl.alu_op;
   assign bus.InstrCount  = cnt;
   assign bus.Halted      = halted;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Self-checking bench for cpu_multicycle_control: instruction-level model of the
// expected per-cycle control word, retire count and halt flag, plus literal checks.
module tb_cpu_multicycle_control;

   typedef enum {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

   logic Clock;
   logic Reset;
   logic Reset2;

   cpu_multicycle_control_if #(.CNT_W(32), .OPC_W(11)) bus ();
   cpu_multicycle_control_if #(.CNT_W(4),  .OPC_W(11)) bus2 ();

   cpu_multicycle_control #(.CNT_W(32), .OPC_W(11)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   cpu_multicycle_control #(.CNT_W(4), .OPC_W(11)) dut2 (
      .Clock (Clock),
      .Reset (Reset2),
      .bus   (bus2)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,
   //  Reg2Loc,MemtoReg,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0]}
   function automatic logic [14:0] cw(
      input bit pcw, pcwc, pcs, iord, mrd, mwr, irw,
      input bit r2l, m2r, rw, sa,
      input bit [1:0] sb, op
   );
      return {pcw, pcwc, pcs, iord, mrd, mwr, irw, r2l, m2r, rw, sa, sb, op};
   endfunction

   localparam logic [14:0] W_PCW    = cw(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_IRW    = cw(0,0,0,0,0,0,1,0,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_R2L    = cw(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_FETCH  = cw(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00);
   localparam logic [14:0] W_DECODE = cw(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00);
   localparam logic [14:0] W_EXEC_R = cw(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10);
   localparam logic [14:0] W_WB_R   = cw(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00);
   localparam logic [14:0] W_ADDR   = cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00);
   localparam logic [14:0] W_MRD    = cw(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_WB_M   = cw(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00);
   localparam logic [14:0] W_MWR    = cw(0,0,0,1,0,1,0,1,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_CBZ    = cw(0,1,1,0,0,0,0,1,0,0,1,2'b00,2'b01);
   localparam logic [14:0] W_BR     = cw(1,0,1,0,0,0,0,0,0,0,0,2'b00,2'b00);
   localparam logic [14:0] W_HALT   = 15'd0;

   localparam logic [10:0] C_ADD  = 11'b10001011000;
   localparam logic [10:0] C_SUB  = 11'b11001011000;
   localparam logic [10:0] C_AND  = 11'b10001010000;
   localparam logic [10:0] C_ORR  = 11'b10101010000;
   localparam logic [10:0] C_LDUR = 11'b11111000010;
   localparam logic [10:0] C_STUR = 11'b11111000000;
   localparam logic [10:0] C_CBZ  = 11'b10110100101;
   localparam logic [10:0] C_B    = 11'b00010110011;
   localparam logic [10:0] C_ILL  = 11'b11111111111;

   int          n_cmp;
   int          n_bad;
   int          cyc;
   logic        exp_valid;
   logic [14:0] exp_vec;
   logic [31:0] exp_cnt;
   logic        exp_halted;
   string       exp_name;
   logic [14:0] act;

   assign act = {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
                 bus.MemRead, bus.MemWrite, bus.IRWrite, bus.Reg2Loc,
                 bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ALUOp};

   function automatic kind_t kind_of(input logic [10:0] o);
      logic [7:0] hi8;
      logic [5:0] hi6;
      hi8 = o[10:3];
      hi6 = o[10:5];
      if (o == C_ADD || o == C_SUB || o == C_AND || o == C_ORR) return K_R;
      if (o == C_LDUR) return K_LD;
      if (o == C_STUR) return K_ST;
      if (hi8 == 8'b10110100) return K_CBZ;
      if (hi6 == 6'b000101) return K_B;
      return K_ILL;
   endfunction

   always @(negedge Clock) begin
      if (exp_valid) begin
         n_cmp++;
         if (act !== exp_vec || bus.InstrCount !== exp_cnt ||
             bus.Halted !== exp_halted) begin
            n_bad++;
            $display("FAIL cyc%0d %s: got ctl=%b cnt=%0d halt=%b, want ctl=%b cnt=%0d halt=%b",
                     cyc, exp_name, act, bus.InstrCount, bus.Halted,
                     exp_vec, exp_cnt, exp_halted);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic step(input logic mr, input logic [14:0] w, input string nm);
      bus.MemReady = mr;
      exp_vec      = w;
      exp_name     = nm;
      exp_valid    = 1'b1;
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic run_instr(input logic [10:0] opc, input int fw, input int mw,
                            input logic z, output int ncyc);
      kind_t k;
      int    c0;
      k  = kind_of(opc);
      c0 = cyc;
      bus.Opcode = opc;
      bus.Zero   = z;
      for (int i = 0; i < fw; i++) step(1'b0, W_FETCH, "fetch_wait");
      step(1'b1, W_FETCH | W_PCW | W_IRW, "fetch");
      step(1'b1, (k == K_ST || k == K_CBZ) ? (W_DECODE | W_R2L) : W_DECODE, "decode");
      case (k)
         K_R: begin
            step(1'b1, W_EXEC_R, "exec_r");
            step(1'b1, W_WB_R, "wb_r");
         end
         K_LD: begin
            step(1'b1, W_ADDR, "addr");
            for (int i = 0; i < mw; i++) step(1'b0, W_MRD, "mrd_wait");
            step(1'b1, W_MRD, "mrd");
            step(1'b1, W_WB_M, "wb_m");
         end
         K_ST: begin
            step(1'b1, W_ADDR, "addr");
            for (int i = 0; i < mw; i++) step(1'b0, W_MWR, "mwr_wait");
            step(1'b1, W_MWR, "mwr");
         end
         K_CBZ: step(1'b1, W_CBZ, "cbz");
         K_B:   step(1'b1, W_BR, "br");
         default: begin
            exp_halted = 1'b1;
            for (int i = 0; i < 10; i++) step(1'((i % 2) == 0), W_HALT, "halt");
         end
      endcase
      if (k != K_ILL) exp_cnt = exp_cnt + 32'd1;
      ncyc = cyc - c0;
   endtask

   task automatic do_reset();
      exp_valid    = 1'b0;
      bus.MemReady = 1'b0;
      Reset        = 1'b1;
      @(posedge Clock);
      #1;
      check("rst_memread", 32'(bus.MemRead), 32'd1);
      check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
      check("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
      check("rst_count", bus.InstrCount, 32'd0);
      check("rst_halted", 32'(bus.Halted), 32'd0);
      Reset      = 1'b0;
      exp_cnt    = 32'd0;
      exp_halted = 1'b0;
   endtask

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c_before;
      n_cmp       = 0;
      n_bad       = 0;
      cyc         = 0;
      exp_valid   = 1'b0;
      exp_vec     = '0;
      exp_cnt     = 32'd0;
      exp_halted  = 1'b0;
      exp_name    = "idle";
      Reset       = 1'b1;
      Reset2      = 1'b1;
      bus.Opcode  = C_ADD;
      bus.Zero    = 1'b0;
      bus.MemReady = 1'b0;
      bus2.Opcode = C_B;
      bus2.Zero   = 1'b0;
      bus2.MemReady = 1'b1;

      do_reset();

      run_instr(C_ADD, 0, 0, 1'b0, n);
      check("add_cycles", 32'(n), 32'd4);
      check("add_count", bus.InstrCount, 32'd1);

      run_instr(C_SUB, 2, 0, 1'b0, n);
      check("sub_fetchwait_cycles", 32'(n), 32'd6);

      run_instr(C_LDUR, 0, 3, 1'b0, n);
      check("ldur_wait_cycles", 32'(n), 32'd8);

      run_instr(C_STUR, 0, 0, 1'b0, n);
      check("stur_cycles", 32'(n), 32'd4);

      run_instr(C_STUR, 1, 2, 1'b0, n);

      c_before = 32'(bus.InstrCount);
      run_instr(C_CBZ, 0, 0, 1'b1, n);
      check("cbz_z1_cycles", 32'(n), 32'd3);
      run_instr(C_CBZ, 0, 0, 1'b0, n);
      check("cbz_z0_cycles", 32'(n), 32'd3);
      check("cbz_count_plus2", bus.InstrCount, 32'(c_before + 2));

      run_instr(C_B, 0, 0, 1'b0, n);
      check("b_cycles", 32'(n), 32'd3);
      run_instr(C_AND, 0, 0, 1'b0, n);
      run_instr(C_ORR, 1, 0, 1'b0, n);
      run_instr(C_LDUR, 0, 0, 1'b0, n);
      check("ldur_cycles", 32'(n), 32'd5);
      check("count_before_halt", bus.InstrCount, 32'd11);

      run_instr(C_ILL, 0, 0, 1'b0, n);
      check("halt_flag", 32'(bus.Halted), 32'd1);
      check("halt_count", bus.InstrCount, 32'd11);

      do_reset();
      run_instr(C_ADD, 0, 0, 1'b0, n);
      check("post_halt_count", bus.InstrCount, 32'd1);

      // STUR interrupted by reset while waiting on memory
      bus.Opcode = C_STUR;
      step(1'b1, W_FETCH | W_PCW | W_IRW, "fetch");
      step(1'b1, W_DECODE | W_R2L, "decode");
      step(1'b1, W_ADDR, "addr");
      step(1'b0, W_MWR, "mwr_wait");
      exp_valid    = 1'b0;
      bus.MemReady = 1'b0;
      #1;
      check("mwr_memwrite_pre", 32'(bus.MemWrite), 32'd1);
      Reset = 1'b1;
      #1;
      check("mwr_rst_memwrite", 32'(bus.MemWrite), 32'd0);
      check("mwr_rst_memread", 32'(bus.MemRead), 32'd1);
      check("mwr_rst_iord", 32'(bus.IorD), 32'd0);
      check("mwr_rst_count", bus.InstrCount, 32'd0);
      @(posedge Clock);
      #1;
      Reset      = 1'b0;
      exp_cnt    = 32'd0;
      exp_halted = 1'b0;
      run_instr(C_ADD, 0, 0, 1'b0, n);
      check("post_mwr_rst_count", bus.InstrCount, 32'd1);

      // 4-bit counter wrap with back-to-back branches
      exp_valid = 1'b0;
      Reset2    = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         repeat (3) @(posedge Clock);
         #1;
         check($sformatf("wrap_cnt_%0d", k), 32'(bus2.InstrCount), 32'(k % 16));
      end
      check("wrap_final", 32'(bus2.InstrCount), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
